// File: rtl/ps2kbd_pkg.sv
// Shared definitions for the PS/2 keyboard controller: register decode,
// STATUS bit positions, frame length and receiver state encoding.
`timescale 1ns/1ps
package ps2kbd_pkg;

  // Register select: the single decoded address bit
  localparam int unsigned REG_SEL_BIT  = 2;
  localparam logic        REG_DATA     = 1'b0;
  localparam logic        REG_STATUS   = 1'b1;

  // STATUS register layout
  localparam int unsigned ST_NONEMPTY  = 0;
  localparam int unsigned ST_OVF       = 1;
  localparam int unsigned ST_ERR       = 2;
  localparam int unsigned ST_IE        = 3;
  localparam int unsigned ST_COUNT_LSB = 8;
  localparam int unsigned ST_COUNT_W   = 9;

  // Bits shifted after the start bit: 8 data, parity, stop
  localparam int unsigned FRAME_BITS   = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } rx_state_e;

endpackage

// File: rtl/if_wb.sv
// Minimal Wishbone-classic bus bundle (32-bit data, byte selects).
// slave modport: cyc/stb/we/adr/sel/dat_i in, dat_o/ack out.
`timescale 1ns/1ps
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack;

  modport slave  (input  cyc, stb, we, adr, sel, dat_i, output dat_o, ack);
  modport master (output cyc, stb, we, adr, sel, dat_i, input  dat_o, ack);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead output.
// Ports: push/din write, pop reads (dout is the current head),
// full/empty/count status. A push while full is accepted only when a pop
// in the same cycle frees the slot; a pop on empty is ignored.
`timescale 1ns/1ps
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array, no reset needed
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2kbd_ctrl.sv
// PS/2 keyboard receiver with scancode FIFO and Wishbone register port.
// Ports: clk_i/rst_ni system clock and async active-low reset; bus is the
// Wishbone responder (DATA at adr[2]=0, STATUS at adr[2]=1); ps2_clk and
// ps2_data are the raw keyboard pins; interrupt is the registered level IRQ.
`timescale 1ns/1ps
module ps2kbd_ctrl
  import ps2kbd_pkg::*;
#(
  parameter int unsigned CLKFREQ     = 10000000,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned TIMEOUT_CYC = CLKFREQ / 10000
) (
  input  logic clk_i,
  input  logic rst_ni,
  if_wb.slave  bus,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic interrupt
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC + 1);

  // Pin synchronizers; idle-high so reset never fabricates an edge
  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_prev;
  logic       fall;
  logic       bit_in;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[1];
  assign bit_in = data_sync[1];

  // Inter-edge watchdog, saturating at the limit
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYC));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          wd_cnt <= '0;
    else if (fall)        wd_cnt <= '0;
    else if (!wd_expired) wd_cnt <= wd_cnt + WD_W'(1);
  end

  // Receiver FSM
  rx_state_e                state_q;
  rx_state_e                state_d;
  logic [FRAME_BITS-1:0]    shreg;
  logic [3:0]               bit_cnt;
  logic                     frame_ok;
  logic                     push_c;
  logic                     frame_err_c;

  // shreg: [7:0] data, [8] parity, [9] stop once full
  assign frame_ok = (^shreg[8:0]) & shreg[9];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    push_c      = 1'b0;
    frame_err_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall && !bit_in) state_d = SHIFT;
      end
      SHIFT: begin
        if (wd_expired) begin
          state_d = IDLE;
        end else if (fall && (bit_cnt == 4'(FRAME_BITS - 1))) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (frame_ok) push_c      = 1'b1;
        else          frame_err_c = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bits arrive LSB first, so shift in from the top
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (state_q == IDLE) begin
      bit_cnt <= '0;
    end else if ((state_q == SHIFT) && fall) begin
      shreg   <= {bit_in, shreg[FRAME_BITS-1:1]};
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // Scancode FIFO
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             pop_c;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push_c),
    .pop    (pop_c),
    .din    (shreg[7:0]),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Bus access: request cycle does the side effects, ack follows one cycle later
  logic        ack_q;
  logic [31:0] dat_q;
  logic        ie_q;
  logic        err_q;
  logic        ovf_q;
  logic        req_c;
  logic        sel_status_c;
  logic        wr_status_c;
  logic        ovf_set_c;
  logic [31:0] status_word_c;
  logic [31:0] rdata_c;
  logic        unused_bus;

  assign req_c        = bus.cyc & bus.stb & ~ack_q;
  assign sel_status_c = (bus.adr[REG_SEL_BIT] == REG_STATUS);
  assign pop_c        = req_c & ~bus.we & ~sel_status_c;
  assign wr_status_c  = req_c & bus.we & sel_status_c;
  // A same-cycle pop frees the slot, so only a non-popped full FIFO overflows
  assign ovf_set_c    = push_c & fifo_full & ~pop_c;
  assign unused_bus   = ^{bus.sel, bus.adr[31:3], bus.adr[1:0],
                          bus.dat_i[31:4], bus.dat_i[0]};

  always_comb begin
    status_word_c = '0;
    status_word_c[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
    status_word_c[ST_IE]       = ie_q;
    status_word_c[ST_ERR]      = err_q;
    status_word_c[ST_OVF]      = ovf_q;
    status_word_c[ST_NONEMPTY] = ~fifo_empty;
  end

  always_comb begin
    rdata_c = '0;
    if (sel_status_c)     rdata_c = status_word_c;
    else if (!fifo_empty) rdata_c = {24'h0, fifo_dout};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      ie_q      <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      ack_q <= req_c;
      dat_q <= (req_c && !bus.we) ? rdata_c : '0;
      if (wr_status_c) ie_q <= bus.dat_i[ST_IE];
      // Sticky flags: a new event wins over a simultaneous clear
      err_q <= frame_err_c | (err_q & ~(wr_status_c & bus.dat_i[ST_ERR]));
      ovf_q <= ovf_set_c   | (ovf_q & ~(wr_status_c & bus.dat_i[ST_OVF]));
      interrupt <= ie_q & (~fifo_empty | ovf_q | err_q);
    end
  end

  assign bus.ack   = ack_q;
  assign bus.dat_o = dat_q;

endmodule

// File: tb/tb_ps2kbd_ctrl.sv
// Directed self-checking bench for ps2kbd_ctrl.
`timescale 1ns/1ps
module tb_ps2kbd_ctrl;
  import ps2kbd_pkg::*;

  localparam logic [31:0] A_DATA   = 32'h0000_0000;
  localparam logic [31:0] A_STATUS = 32'h0000_0004;

  logic clk;
  logic rst_ni;
  logic ps2_clk;
  logic ps2_data;
  logic interrupt;

  int tests_run;
  int tests_failed;

  if_wb wb();

  ps2kbd_ctrl dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .bus       (wb),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .interrupt (interrupt)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // {stop, odd parity (optionally inverted), data, start}
  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic flip);
    return {1'b1, (~^d) ^ flip, d, 1'b0};
  endfunction

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (10) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (20) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip);
    logic [10:0] bits;
    bits = mk_frame(d, flip);
    for (int i = 0; i < 11; i++) send_bit(bits[i]);
  endtask

  task automatic wb_start(input logic [31:0] adr, input logic we, input logic [31:0] d);
    wb.cyc   = 1'b1;
    wb.stb   = 1'b1;
    wb.we    = we;
    wb.adr   = adr;
    wb.sel   = 4'hF;
    wb.dat_i = d;
  endtask

  task automatic wb_finish(output logic [31:0] d);
    logic ok;
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (wb.ack) begin
        d  = wb.dat_o;
        ok = 1'b1;
        break;
      end
    end
    wb.cyc = 1'b0;
    wb.stb = 1'b0;
    wb.we  = 1'b0;
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL wb_ack_timeout: no ack within 8 cycles");
    end
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] d);
    @(posedge clk);
    #1 wb_start(adr, 1'b0, 32'h0);
    wb_finish(d);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] wd);
    logic [31:0] dummy;
    @(posedge clk);
    #1 wb_start(adr, 1'b1, wd);
    wb_finish(dummy);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (wb.ack !== 1'b0 || wb.dat_o !== 32'h0 || interrupt !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: ack=%b dat_o=%h irq=%b, required 0/0/0", wb.ack, wb.dat_o, interrupt);
    end
    tests_run++;
    if (dut.state_q !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d required %0d", dut.state_q, IDLE);
    end
    rst_ni = 1'b1;
    repeat (3) @(posedge clk);
    wb_read(A_STATUS, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_status: got %h required %h", d, 32'h0);
    end
  endtask

  task automatic test_ack_timing();
    @(posedge clk);
    #1 wb_start(A_STATUS, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    tests_run++;
    if (wb.ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL ack_first: got %b required 1", wb.ack);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (wb.ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_single: got %b required 0", wb.ack);
    end
    wb.cyc = 1'b0;
    wb.stb = 1'b0;
  endtask

  task automatic test_frame_basic();
    logic [31:0] d;
    send_frame(8'h1C, 1'b0);
    wb_read(A_STATUS, d);
    tests_run++;
    if (d !== 32'h0000_0101) begin
      tests_failed++;
      $display("FAIL basic_status: got %h required %h", d, 32'h0000_0101);
    end
    wb_read(A_DATA, d);
    tests_run++;
    if (d !== 32'h0000_001C) begin
      tests_failed++;
      $display("FAIL basic_data: got %h required %h", d, 32'h0000_001C);
    end
    // Other address bits ignored: 0x14 still decodes as STATUS
    wb_read(32'h0000_0014, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL basic_empty_after: got %h required %h", d, 32'h0);
    end
  endtask

  task automatic test_parity_err();
    logic [31:0] d;
    send_frame(8'h1C, 1'b1);
    wb_read(A_STATUS, d);
    tests_run++;
    if (d !== 32'h0000_0004) begin
      tests_failed++;
      $display("FAIL parity_status: got %h required %h", d, 32'h0000_0004);
    end
    wb_read(A_DATA, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL empty_data_read: got %h required %h", d, 32'h0);
    end
    wb_write(A_STATUS, 32'h0000_0008);
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (interrupt !== 1'b1) begin
      tests_failed++;
      $display("FAIL parity_irq: got %b required 1", interrupt);
    end
    wb_write(A_STATUS, 32'h0000_000E);
    wb_write(A_DATA, 32'h0000_00FF);
    wb_read(A_STATUS, d);
    tests_run++;
    if (d !== 32'h0000_0008) begin
      tests_failed++;
      $display("FAIL err_clear: got %h required %h", d, 32'h0000_0008);
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (interrupt !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_clear: got %b required 0", interrupt);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    for (int i = 0; i < 17; i++) send_frame(8'(8'h10 + i), 1'b0);
    wb_read(A_STATUS, d);
    tests_run++;
    if (d !== 32'h0000_100B) begin
      tests_failed++;
      $display("FAIL ovf_status: got %h required %h", d, 32'h0000_100B);
    end
    tests_run++;
    if (interrupt !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_irq: got %b required 1", interrupt);
    end
    for (int i = 0; i < 16; i++) begin
      wb_read(A_DATA, d);
      tests_run++;
      if (d !== 32'(8'h10 + i)) begin
        tests_failed++;
        $display("FAIL ovf_order[%0d]: got %h required %h", i, d, 32'(8'h10 + i));
      end
    end
    wb_read(A_STATUS, d);
    tests_run++;
    if (d !== 32'h0000_000A) begin
      tests_failed++;
      $display("FAIL ovf_drained: got %h required %h", d, 32'h0000_000A);
    end
    wb_write(A_STATUS, 32'h0000_0006);
    wb_read(A_STATUS, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL ovf_clear: got %h required %h", d, 32'h0);
    end
  endtask

  task automatic test_timeout();
    logic [10:0] bits;
    logic [31:0] d;
    bits = mk_frame(8'h77, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(bits[i]);
    repeat (1500) @(posedge clk);
    #1;
    tests_run++;
    if (dut.state_q !== IDLE) begin
      tests_failed++;
      $display("FAIL timeout_state: got %0d required %0d", dut.state_q, IDLE);
    end
    wb_read(A_STATUS, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL timeout_status: got %h required %h", d, 32'h0);
    end
    send_frame(8'hF0, 1'b0);
    wb_read(A_DATA, d);
    tests_run++;
    if (d !== 32'h0000_00F0) begin
      tests_failed++;
      $display("FAIL timeout_next: got %h required %h", d, 32'h0000_00F0);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits;
    logic [31:0] d;
    logic [31:0] exp;
    for (int i = 0; i < 16; i++) send_frame(8'(8'h40 + i), 1'b0);
    wb_read(A_STATUS, d);
    tests_run++;
    if (d !== 32'h0000_1001) begin
      tests_failed++;
      $display("FAIL full_status: got %h required %h", d, 32'h0000_1001);
    end
    bits = mk_frame(8'hAA, 1'b0);
    for (int i = 0; i < 10; i++) send_bit(bits[i]);
    // Stop-bit edge: CHECK lands 3 cycles after the pin falls
    ps2_data = bits[10];
    repeat (10) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1 wb_start(A_DATA, 1'b0, 32'h0);
    wb_finish(d);
    tests_run++;
    if (d !== 32'h0000_0040) begin
      tests_failed++;
      $display("FAIL pushpop_data: got %h required %h", d, 32'h0000_0040);
    end
    repeat (20) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (10) @(posedge clk);
    wb_read(A_STATUS, d);
    tests_run++;
    if (d !== 32'h0000_1001) begin
      tests_failed++;
      $display("FAIL pushpop_status: got %h required %h", d, 32'h0000_1001);
    end
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 32'(8'h41 + i) : 32'h0000_00AA;
      wb_read(A_DATA, d);
      tests_run++;
      if (d !== exp) begin
        tests_failed++;
        $display("FAIL pushpop_order[%0d]: got %h required %h", i, d, exp);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [10:0] bits;
    logic [31:0] d;
    send_frame(8'h33, 1'b0);
    wb_write(A_STATUS, 32'h0000_0008);
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (interrupt !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_irq: got %b required 1", interrupt);
    end
    bits = mk_frame(8'hC3, 1'b0);
    for (int i = 0; i < 6; i++) send_bit(bits[i]);
    ps2_data = bits[6];
    repeat (10) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_ni = 1'b0;
    #5;
    tests_run++;
    if (wb.ack !== 1'b0 || wb.dat_o !== 32'h0 || interrupt !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: ack=%b dat_o=%h irq=%b, required 0/0/0", wb.ack, wb.dat_o, interrupt);
    end
    tests_run++;
    if (dut.state_q !== IDLE || dut.fifo_count !== '0) begin
      tests_failed++;
      $display("FAIL midreset_state: state=%0d count=%0d, required %0d/0", dut.state_q, dut.fifo_count, IDLE);
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    repeat (20) @(posedge clk);
    wb_read(A_STATUS, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL midreset_status: got %h required %h", d, 32'h0);
    end
    send_frame(8'h5A, 1'b0);
    wb_read(A_DATA, d);
    tests_run++;
    if (d !== 32'h0000_005A) begin
      tests_failed++;
      $display("FAIL midreset_next: got %h required %h", d, 32'h0000_005A);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_ni       = 1'b0;
    ps2_clk      = 1'b1;
    ps2_data     = 1'b1;
    wb.cyc       = 1'b0;
    wb.stb       = 1'b0;
    wb.we        = 1'b0;
    wb.adr       = '0;
    wb.sel       = '0;
    wb.dat_i     = '0;

    test_reset();
    test_ack_timing();
    test_frame_basic();
    test_parity_err();
    test_overflow();
    test_timeout();
    test_back_to_back();
    test_reset_midframe();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ps2kbd_ctrl.md
PS2KBD_CTRL -- requirements
Module: ps2kbd_ctrl

Interface
REQ-001 SHALL have parameter CLKFREQ, default 10000000, meaning clk_i frequency in Hz.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning scancode FIFO entries (power of two, 2..256).
REQ-003 SHALL have parameter TIMEOUT_CYC, default CLKFREQ/10000, meaning the inter-edge abort limit (100 us).
REQ-004 SHALL have port clk_i, input, width 1: the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_ni, input, width 1: asynchronous active-low reset.
REQ-006 SHALL have port bus, if_wb.slave: Wishbone responder (cyc, stb, we, adr, sel, dat_i, dat_o, ack).
REQ-007 SHALL have port ps2_clk, input, width 1: raw keyboard clock pin.
REQ-008 SHALL have port ps2_data, input, width 1: raw keyboard data pin.
REQ-009 SHALL have port interrupt, output, width 1: level interrupt to interrupt_encoder.

Function
REQ-010 SHALL pass ps2_clk and ps2_data through two-flop synchronizers, and detect a falling edge as sync_clk previous=1, current=0.
REQ-011 SHALL use receiver FSM states IDLE, SHIFT, CHECK.
REQ-012 IDLE SHALL go to SHIFT on a falling edge with data=0 (start bit), and SHALL ignore an edge with data=1.
REQ-013 SHIFT SHALL sample 8 data bits LSB first, then the parity bit, then the stop bit, one per falling edge, using a 4-bit bit counter, then go to CHECK.
REQ-014 CHECK SHALL last one cycle and accept the frame only when parity is odd over data+parity and stop=1.
REQ-015 CHECK SHALL otherwise set sticky ERR, discard the byte and return to IDLE.
REQ-016 A watchdog counter SHALL reset on every falling edge; if it reaches TIMEOUT_CYC while in SHIFT, the FSM SHALL return to IDLE, discard the frame and leave ERR unchanged.
REQ-017 An accepted byte SHALL be written to the FIFO in the CHECK cycle.
REQ-018 If the FIFO is full, the byte SHALL be dropped, sticky OVF set and FIFO contents left unchanged.
REQ-019 The register map SHALL decode adr[2]: 0 = DATA, 1 = STATUS; other adr bits and sel SHALL be ignored.
REQ-020 A DATA read SHALL return {24'h0, head byte} and pop one entry.
REQ-021 A DATA read on an empty FIFO SHALL return 32'h0 and not pop.
REQ-022 A STATUS read SHALL return {count[8:0] in bits 16:8, IE bit3, ERR bit2, OVF bit1, nonempty bit0}, other bits 0.
REQ-023 A STATUS write SHALL set IE=dat_i[3] and clear ERR/OVF wherever dat_i[2]/dat_i[1]=1.
REQ-024 DATA writes SHALL be accepted (acked) with no effect.
REQ-025 ack SHALL assert exactly one cycle after the first cycle with cyc&stb&!ack, last one cycle, and every access SHALL complete in two cycles.
REQ-026 dat_o SHALL be valid in the ack cycle.
REQ-027 Pop and push on the same cycle SHALL both occur, with count unchanged; push-while-full-and-pop SHALL succeed (pop frees the slot first).
REQ-028 interrupt SHALL be registered and equal IE & (nonempty | OVF | ERR).
REQ-029 FIFO pointers SHALL be log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.

Reset
REQ-030 While rst_ni=0, the block SHALL be in state IDLE with FIFO empty (pointers and count 0), IE=0, ERR=0, OVF=0, ack=0, dat_o=0, interrupt=0, watchdog 0, and synchronizer flops 1.
REQ-031 Reset asserted mid-frame or mid-bus-cycle SHALL abort immediately with no partial byte retained, and the first edge after release SHALL be treated as a potential start bit.

Structure
REQ-032 Register offsets, STATUS bit positions and the FSM state enum SHALL live in a shared package ps2kbd_pkg.
REQ-033 The FIFO SHALL be a separate sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count).
REQ-034 The receiver FSM and the bus logic SHALL reside in ps2kbd_ctrl.

Verification
REQ-035 Frame 0x1C (parity 0, stop 1): DATA read returns 32'h0000001C and STATUS bit0 then becomes 0.
REQ-036 Frame 0x1C with parity 1: ERR=1, FIFO empty, and interrupt=1 once IE is set; a STATUS write of 0x0E clears ERR.
REQ-037 17 valid frames with no reads: count=16, OVF=1, and 16 DATA reads return the first 16 bytes in order.
REQ-038 Start bit then 4 bits then 150 us idle: FSM back in IDLE, no push, ERR=0, and the next 0xF0 frame is received correctly.
REQ-039 DATA read in the same cycle as a CHECK push at count=16: the read returns the oldest byte, the new byte is stored, OVF=0 and count=16.
REQ-040 rst_ni pulse during bit 5 of a frame: all outputs 0, FIFO empty, and the following 0x5A frame is received correctly.
